alu_result_stage: RTL and testbench
===================================

Name: alu_result_stage

Overview:
Registered output stage directly downstream of the 16-bit ALU.
- Captures the ALU result C and flags S, Z, P, Cout, Ov into a 2-entry buffer, using valid/ready handshakes on both sides.
- Evaluates a selectable branch condition on the head entry.
- Keeps a sticky overflow indicator and a saturating overflow counter for debug and exception logic.

Parameters:
- DW, 16, data width of the ALU result.
- CW, 8, width of the overflow event counter.

Ports:
- clk  input  1  Rising-edge clock; the only clock.
- rst  input  1  Reset. Synchronous, active-high.
- in_valid  input  1  ALU result and flags are valid this cycle.
- in_ready  output  1  Stage can accept an entry this cycle.
- c_in  input  DW  ALU result C.
- s_in  input  1  ALU sign flag.
- z_in  input  1  ALU zero flag.
- p_in  input  1  ALU parity flag.
- cout_in  input  1  ALU carry-out.
- ov_in  input  1  ALU signed overflow.
- out_valid  output  1  Head entry is valid.
- out_ready  input  1  Consumer accepts the head entry.
- out_data  output  DW  Head entry result.
- out_flags  output  5  Head entry flags, packed {S,Z,P,Cout,Ov} (bit4..bit0).
- cond_sel  input  3  Condition select.
- cond_true  output  1  Selected condition evaluated on the head entry.
- ov_clr  input  1  Clear sticky overflow and counter.
- ov_sticky  output  1  Set once any accepted entry had Ov=1.
- ov_count  output  CW  Saturating count of accepted entries with Ov=1.

Behaviour:
- Reset (rst=1 at a clk edge):
  - Storage pointers, occupancy, ov_sticky and ov_count go to 0.
  - out_valid=0; out_data and out_flags read 0.
  - in_ready becomes 1 from the first cycle after reset is released.
  - Reset mid-transfer discards all stored entries; no partial state survives.
- Push and pop:
  - Push occurs when in_valid && in_ready at a clk edge.
  - Pop occurs when out_valid && out_ready at a clk edge.
- Storage: 2-entry FIFO, entry = {c_in, s_in, z_in, p_in, cout_in, ov_in}.
  - Latency: an entry pushed at edge N is on out_data/out_flags with out_valid=1 after edge N (visible in cycle N+1).
  - No combinational input-to-output path.
- in_ready = (occupancy < 2). It is registered-state derived only; no combinational dependence on out_ready.
- Boundary conditions:
  - Full (occupancy 2): in_ready=0 and the input is ignored. A pop in that cycle makes in_ready=1 the next cycle.
  - Simultaneous push and pop at occupancy 1: occupancy stays 1; the new entry becomes head after the pop.
  - Empty: out_valid=0 and out_ready is ignored.
- Ordering and stability:
  - Strict FIFO order; no entry is dropped or duplicated.
  - While out_valid=1 and out_ready=0, out_data and out_flags hold stable.
- cond_true: combinational from the head entry and cond_sel; forced to 0 when out_valid=0.
  - 0: always 1.
  - 1: Z.
  - 2: !Z.
  - 3: Cout.
  - 4: !Cout.
  - 5: S.
  - 6: Ov.
  - 7: S^Ov (signed less-than).
- Overflow tracking is updated on push, not pop:
  - A push with ov_in=1 sets ov_sticky and increments ov_count.
  - ov_count saturates at 2^CW-1 with no wrap.
  - ov_clr=1 alone: ov_sticky=0 and ov_count=0 next cycle.
  - ov_clr=1 together with a push having ov_in=1: the push wins, giving ov_sticky=1 and ov_count=1.
- Flags pass through unmodified. The stage never recomputes S, Z, P, Cout or Ov.

Test Plan:
- Basic passthrough: after reset, push c_in=16'h3896, flags {0,0,p,0,0}, out_ready=1 -> next cycle out_valid=1, out_data=16'h3896, out_flags={0,0,p,0,0}; cond_sel=2 gives cond_true=1; following cycle out_valid=0.
- Carry case: push c_in=16'h23df with cout=1, ov=0 (16'h34cd+16'hef12) -> out_flags[1]=1; cond_sel=3 gives cond_true=1, cond_sel=4 gives 0, cond_sel=6 gives 0.
- Backpressure/full: out_ready=0, push 16'h0001 then 16'h0002 -> in_ready=0 after the second push; a third in_valid with 16'h0003 is ignored. Then out_ready=1 -> outputs 0001, 0002 in order; in_ready returns to 1 the cycle after the first pop.
- Push and pop at occupancy 1: one entry held, then push 16'h00AA while popping -> occupancy stays 1, next head = 16'h00AA, out_valid stays 1.
- Overflow tracking: push 3 entries with ov_in=1 -> ov_sticky=1, ov_count=3. Assert ov_clr together with a 4th Ov push -> ov_count=1, ov_sticky=1. With CW=2, push 5 Ov entries -> ov_count holds at 3.
- Reset mid-operation: two entries buffered, ov_count=2, assert rst for one cycle -> out_valid=0, in_ready=1 after release, ov_sticky=0, ov_count=0, and the old entries never appear.

Source files
------------

// File: rtl/alu_result_stage.sv
// Registered output stage behind the 16-bit ALU: 2-entry result/flag FIFO with valid/ready
// on both sides, head-entry branch condition, and sticky/saturating overflow tracking.
module alu_result_stage #(
    parameter int DW = 16,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] c_in,
    input  logic          s_in,
    input  logic          z_in,
    input  logic          p_in,
    input  logic          cout_in,
    input  logic          ov_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [4:0]    out_flags,
    input  logic [2:0]    cond_sel,
    output logic          cond_true,
    input  logic          ov_clr,
    output logic          ov_sticky,
    output logic [CW-1:0] ov_count
);

    localparam int EW = DW + 5;
    localparam logic [CW-1:0] OV_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] OV_ONE = {{(CW-1){1'b0}}, 1'b1};

    logic [EW-1:0] mem_r [2];
    logic          wr_ptr_r;
    logic          rd_ptr_r;
    logic [1:0]    count_r;
    logic          ov_sticky_r;
    logic [CW-1:0] ov_count_r;

    logic          push_s;
    logic          pop_s;
    logic [EW-1:0] head_s;
    logic          cond_s;

    // Ready/valid come from occupancy only, so out_ready never feeds in_ready.
    assign in_ready  = (count_r < 2'd2);
    assign out_valid = (count_r != 2'd0);
    assign push_s    = in_valid & in_ready;
    assign pop_s     = out_valid & out_ready;

    // Entry storage and write pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_r[0] <= '0;
            mem_r[1] <= '0;
            wr_ptr_r <= 1'b0;
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= {c_in, s_in, z_in, p_in, cout_in, ov_in};
            wr_ptr_r        <= ~wr_ptr_r;
        end
    end

    // Read pointer and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Overflow tracking counts accepted entries; a push with Ov beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ov_sticky_r <= 1'b0;
            ov_count_r  <= '0;
        end else if (push_s && ov_in) begin
            ov_sticky_r <= 1'b1;
            if (ov_clr) begin
                ov_count_r <= OV_ONE;
            end else if (ov_count_r != OV_MAX) begin
                ov_count_r <= ov_count_r + OV_ONE;
            end
        end else if (ov_clr) begin
            ov_sticky_r <= 1'b0;
            ov_count_r  <= '0;
        end
    end

    // Head entry, reading as zero when empty.
    always_comb begin
        head_s = '0;
        if (out_valid) begin
            head_s = mem_r[rd_ptr_r];
        end else begin
            head_s = '0;
        end
    end

    assign out_data  = head_s[EW-1:5];
    assign out_flags = head_s[4:0];

    // Branch condition on head flags {S,Z,P,Cout,Ov}.
    always_comb begin
        cond_s = 1'b0;
        case (cond_sel)
            3'd0:    cond_s = 1'b1;
            3'd1:    cond_s = head_s[3];
            3'd2:    cond_s = ~head_s[3];
            3'd3:    cond_s = head_s[1];
            3'd4:    cond_s = ~head_s[1];
            3'd5:    cond_s = head_s[4];
            3'd6:    cond_s = head_s[0];
            3'd7:    cond_s = head_s[4] ^ head_s[0];
            default: cond_s = 1'b0;
        endcase
    end

    assign cond_true = out_valid & cond_s;
    assign ov_sticky = ov_sticky_r;
    assign ov_count  = ov_count_r;

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: queue scoreboard checked every cycle, a condition-code vector
// table, and hand sequences for backpressure, overflow tracking and reset.
module tb_alu_result_stage;

    logic        clk = 1'b0;
    logic        rst, in_valid, s_in, z_in, p_in, cout_in, ov_in, out_ready, ov_clr;
    logic [15:0] c_in;
    logic [2:0]  cond_sel;

    logic        in_ready, out_valid, cond_true, ov_sticky;
    logic [15:0] out_data;
    logic [4:0]  out_flags;
    logic [7:0]  ov_count;

    logic        sat_in_ready, sat_out_valid, sat_cond_true, sat_ov_sticky;
    logic [15:0] sat_out_data;
    logic [4:0]  sat_out_flags;
    logic [1:0]  sat_ov_count;

    always #5 clk = ~clk;

    alu_result_stage #(.DW(16), .CW(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .c_in(c_in),
        .s_in(s_in), .z_in(z_in), .p_in(p_in), .cout_in(cout_in), .ov_in(ov_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_flags(out_flags), .cond_sel(cond_sel), .cond_true(cond_true),
        .ov_clr(ov_clr), .ov_sticky(ov_sticky), .ov_count(ov_count)
    );

    alu_result_stage #(.DW(16), .CW(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sat_in_ready), .c_in(c_in),
        .s_in(s_in), .z_in(z_in), .p_in(p_in), .cout_in(cout_in), .ov_in(ov_in),
        .out_valid(sat_out_valid), .out_ready(out_ready), .out_data(sat_out_data),
        .out_flags(sat_out_flags), .cond_sel(cond_sel), .cond_true(sat_cond_true),
        .ov_clr(ov_clr), .ov_sticky(sat_ov_sticky), .ov_count(sat_ov_count)
    );

    typedef struct {
        logic [15:0] c;
        logic [4:0]  f;
    } ent_t;

    typedef struct {
        logic [15:0] c;
        logic [4:0]  f;
        logic [2:0]  sel;
        logic        exp_cond;
    } vec_t;

    ent_t q[$];
    int   m_ovc    = 0;
    bit   m_sticky = 1'b0;
    int   n_vec    = 0;
    int   n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference condition as a lookup over the flag bits {S,Z,P,Cout,Ov}.
    function automatic logic cond_ref(input logic [4:0] f, input logic [2:0] sel);
        logic [7:0] tbl;
        tbl = {f[4] ^ f[0], f[0], f[4], ~f[1], f[1], ~f[3], f[3], 1'b1};
        return tbl[sel];
    endfunction

    task automatic drv(input logic v, input logic [15:0] c, input logic [4:0] f,
                       input logic ordy, input logic [2:0] sel, input logic clr);
        in_valid = v;
        c_in     = c;
        {s_in, z_in, p_in, cout_in, ov_in} = f;
        out_ready = ordy;
        cond_sel  = sel;
        ov_clr    = clr;
    endtask

    // One clock: compare against the scoreboard mid-cycle, then advance the model.
    task automatic step();
        bit   push, pop;
        ent_t e;
        @(negedge clk);
        chk("out_valid", out_valid, q.size() != 0);
        chk("in_ready", in_ready, q.size() < 2);
        if (q.size() != 0) begin
            chk("out_data", out_data, q[0].c);
            chk("out_flags", out_flags, q[0].f);
            chk("cond_true", cond_true, cond_ref(q[0].f, cond_sel));
        end else begin
            chk("empty_data", out_data, 16'h0000);
            chk("empty_flags", out_flags, 5'b00000);
            chk("empty_cond", cond_true, 1'b0);
        end
        chk("ov_sticky", ov_sticky, m_sticky);
        chk("ov_count", ov_count, (m_ovc > 255) ? 255 : m_ovc);
        chk("sat_ov_count", sat_ov_count, (m_ovc > 3) ? 3 : m_ovc);
        push = in_valid && (q.size() < 2);
        pop  = (q.size() != 0) && out_ready;
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
            m_ovc    = 0;
            m_sticky = 1'b0;
        end else begin
            if (pop) void'(q.pop_front());
            if (push) begin
                e.c = c_in;
                e.f = {s_in, z_in, p_in, cout_in, ov_in};
                q.push_back(e);
            end
            if (push && ov_in) begin
                m_ovc    = ov_clr ? 1 : m_ovc + 1;
                m_sticky = 1'b1;
            end else if (ov_clr) begin
                m_ovc    = 0;
                m_sticky = 1'b0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        vec_t tbl[13];
        tbl[0]  = '{16'h3896, 5'b00100, 3'd2, 1'b1};
        tbl[1]  = '{16'h3896, 5'b00100, 3'd1, 1'b0};
        tbl[2]  = '{16'h23df, 5'b00010, 3'd3, 1'b1};
        tbl[3]  = '{16'h23df, 5'b00010, 3'd4, 1'b0};
        tbl[4]  = '{16'h23df, 5'b00010, 3'd6, 1'b0};
        tbl[5]  = '{16'h0000, 5'b01100, 3'd1, 1'b1};
        tbl[6]  = '{16'h0000, 5'b01100, 3'd2, 1'b0};
        tbl[7]  = '{16'h8001, 5'b10000, 3'd5, 1'b1};
        tbl[8]  = '{16'h8001, 5'b10000, 3'd7, 1'b1};
        tbl[9]  = '{16'h8000, 5'b10001, 3'd7, 1'b0};
        tbl[10] = '{16'h8000, 5'b10001, 3'd6, 1'b1};
        tbl[11] = '{16'h7fff, 5'b00001, 3'd7, 1'b1};
        tbl[12] = '{16'h1234, 5'b00000, 3'd0, 1'b1};

        rst = 1'b1;
        drv(1'b0, 16'h0000, 5'b00000, 1'b0, 3'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        chk("reset_ready", in_ready, 1'b1);
        chk("reset_count", ov_count, 8'd0);

        // Basic passthrough
        drv(1'b1, 16'h3896, 5'b00100, 1'b1, 3'd2, 1'b0);
        step();
        drv(1'b0, 16'h0000, 5'b00000, 1'b1, 3'd2, 1'b0);
        chk("pass_data", out_data, 16'h3896);
        chk("pass_cond", cond_true, 1'b1);
        step();
        chk("pass_empty", out_valid, 1'b0);

        // Condition table: push one entry, evaluate, pop
        for (int i = 0; i < 13; i++) begin
            drv(1'b1, tbl[i].c, tbl[i].f, 1'b0, tbl[i].sel, 1'b0);
            step();
            drv(1'b0, 16'h0000, 5'b00000, 1'b1, tbl[i].sel, 1'b0);
            chk("tbl_cond", cond_true, tbl[i].exp_cond);
            chk("tbl_flags", out_flags, tbl[i].f);
            step();
        end

        // Backpressure and full
        drv(1'b1, 16'h0001, 5'b00000, 1'b0, 3'd0, 1'b0);
        step();
        drv(1'b1, 16'h0002, 5'b00000, 1'b0, 3'd0, 1'b0);
        step();
        chk("full_ready", in_ready, 1'b0);
        drv(1'b1, 16'h0003, 5'b00000, 1'b0, 3'd0, 1'b0);
        step();
        drv(1'b0, 16'h0000, 5'b00000, 1'b1, 3'd0, 1'b0);
        chk("full_head", out_data, 16'h0001);
        step();
        chk("after_pop_ready", in_ready, 1'b1);
        chk("after_pop_head", out_data, 16'h0002);
        step();
        chk("drained", out_valid, 1'b0);

        // Simultaneous push and pop at occupancy 1
        drv(1'b1, 16'h0055, 5'b00000, 1'b0, 3'd0, 1'b0);
        step();
        drv(1'b1, 16'h00aa, 5'b00000, 1'b1, 3'd0, 1'b0);
        step();
        chk("pp_valid", out_valid, 1'b1);
        chk("pp_head", out_data, 16'h00aa);
        drv(1'b0, 16'h0000, 5'b00000, 1'b1, 3'd0, 1'b0);
        step();

        // Overflow tracking, clear/push priority, saturation on CW=2
        drv(1'b0, 16'h0000, 5'b00000, 1'b1, 3'd0, 1'b1);
        step();
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, 16'h0100 + 16'(i), 5'b00001, 1'b1, 3'd6, 1'b0);
            step();
        end
        drv(1'b0, 16'h0000, 5'b00000, 1'b1, 3'd0, 1'b0);
        chk("ov3_count", ov_count, 8'd3);
        chk("ov3_sticky", ov_sticky, 1'b1);
        drv(1'b1, 16'h0104, 5'b00001, 1'b1, 3'd0, 1'b1);
        step();
        chk("clr_push_count", ov_count, 8'd1);
        chk("clr_push_sticky", ov_sticky, 1'b1);
        drv(1'b0, 16'h0000, 5'b00000, 1'b1, 3'd0, 1'b1);
        step();
        chk("clr_count", ov_count, 8'd0);
        chk("clr_sticky", ov_sticky, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drv(1'b1, 16'h0200 + 16'(i), 5'b00001, 1'b1, 3'd0, 1'b0);
            step();
        end
        chk("sat_hold", sat_ov_count, 2'd3);
        chk("nosat_count", ov_count, 8'd5);
        drv(1'b0, 16'h0000, 5'b00000, 1'b1, 3'd0, 1'b1);
        step();

        // Reset mid-operation
        drv(1'b1, 16'h0111, 5'b00001, 1'b0, 3'd0, 1'b0);
        step();
        drv(1'b1, 16'h0222, 5'b00001, 1'b0, 3'd0, 1'b0);
        step();
        chk("prerst_count", ov_count, 8'd2);
        drv(1'b0, 16'h0000, 5'b00000, 1'b0, 3'd0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_count", ov_count, 8'd0);
        chk("rst_sticky", ov_sticky, 1'b0);
        drv(1'b0, 16'h0000, 5'b00000, 1'b1, 3'd0, 1'b0);
        step();
        chk("rst_ready", in_ready, 1'b1);
        repeat (2) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
